// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
//
// Purpose: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles (one bit per clock plus a
// sign-fix cycle), with MTHI/MTLO writes and registered HI/LO read-out.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_op             launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_operand_a, i_operand_b  multiplicand/dividend, multiplier/divisor
//   i_hi_we, i_lo_we          MTHI/MTLO strobes, data on i_write_data
//   o_busy, o_done, o_div0    status (done is a one-cycle pulse)
//   o_hi_out, o_lo_out        architectural HI/LO registers

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_write_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op_div;
    logic               r_neg_q;     // negate product / quotient
    logic               r_neg_r;     // negate remainder
    logic               r_dz;        // current divide has a zero divisor
    logic [WIDTH-1:0]   r_b_mag;
    logic [2*WIDTH-1:0] r_acc;       // {high/remainder, low/quotient}
    logic               r_busy;
    logic               r_done;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_operand_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_operand_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_operand_a : i_operand_a;
    assign w_b_mag  = w_b_neg ? -i_operand_b : i_operand_b;

    // Shift-add: the carry out of the top half shifts back into the accumulator.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b_mag};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs WIDTH+1 bits before the compare.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_b_mag};
    assign w_div_next = (w_rem_sh >= {1'b0, r_b_mag})
                      ? {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                      : {w_rem_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_b_mag  <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op_div <= i_op[1];
                        r_b_mag  <= w_b_mag;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (i_op[1] && (i_operand_b == '0)) begin
                            // Preload the divide-by-zero result; FIX passes it through unsigned.
                            r_dz    <= 1'b1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_acc   <= {i_operand_a, {WIDTH{1'b1}}};
                            r_state <= S_FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_state <= S_RUN;
                        end
                    end else begin
                        if (i_hi_we) r_hi <= i_write_data;
                        if (i_lo_we) r_lo <= i_write_data;
                    end
                end
                S_RUN: begin
                    r_acc <= r_op_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_op_div) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_div0  <= r_dz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_div0   = r_div0;
    assign o_hi_out = r_hi;
    assign o_lo_out = r_lo;

endmodule
